// File: rtl/cdc_chan_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the cross-domain toggle channel.
interface cdc_chan_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ*DW-1:0]      i_data;
  logic                     i_ack_tgl;
  logic                     o_req_tgl;
  logic [DW-1:0]            o_data;
  logic [$clog2(N_REQ)-1:0] o_sel;
  logic                     o_busy;
  logic [N_REQ-1:0]         o_done;
  logic                     o_timeout;

  modport slave (
    input  i_req, i_data, i_ack_tgl,
    output o_req_tgl, o_data, o_sel, o_busy, o_done, o_timeout
  );

  modport master (
    output i_req, i_data, i_ack_tgl,
    input  o_req_tgl, o_data, o_sel, o_busy, o_done, o_timeout
  );
endinterface

// File: rtl/cdc_chan_arbiter.sv
// Round-robin share of one toggle-handshake CDC channel; grant 1 cycle after request, o_done 3 cycles after ack edge.
// One transfer in flight: requesters hold i_req until their o_done pulse; waits forever for the ack (timeout is only a flag).
module cdc_chan_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  cdc_chan_arbiter_if.slave bus
);

  localparam int             SW      = $clog2(N_REQ);
  localparam int             CW      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CW-1:0]  TO_VAL  = CW'(TIMEOUT_CYC);
  localparam logic [SW-1:0]  SEL_MAX = SW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_rr_ptr;
  logic             r_ack_s1;
  logic             r_ack_s2;
  logic             r_ack_d;
  logic             r_req_tgl;
  logic [DW-1:0]    r_data;
  logic [SW-1:0]    r_sel;
  logic             r_busy;
  logic [N_REQ-1:0] r_done;
  logic             r_timeout;
  logic [CW-1:0]    r_cnt;

  logic             w_ack_edge;
  logic             w_pick_vld;
  logic [SW-1:0]    w_pick;
  logic [DW-1:0]    w_pick_data;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_to_hit;

  // ack_d keeps following ack_s2 in every state, so stray toggles outside WAIT_ACK are absorbed.
  assign w_ack_edge = r_ack_s2 ^ r_ack_d;

  always_comb begin
    int idx;
    idx        = 0;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % N_REQ;
      if (!w_pick_vld && bus.i_req[idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = SW'(idx);
      end
    end
  end

  assign w_pick_data = bus.i_data[int'(w_pick)*DW +: DW];
  assign w_cnt_nxt   = (r_cnt == TO_VAL) ? r_cnt : r_cnt + 1'b1;
  assign w_to_hit    = TO_EN && (w_cnt_nxt == TO_VAL);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_ack_s1  <= 1'b0;
      r_ack_s2  <= 1'b0;
      r_ack_d   <= 1'b0;
      r_req_tgl <= 1'b0;
      r_data    <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_done    <= '0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_ack_s1 <= bus.i_ack_tgl;
      r_ack_s2 <= r_ack_s1;
      r_ack_d  <= r_ack_s2;
      r_done   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_sel     <= w_pick;
            r_data    <= w_pick_data;
            r_req_tgl <= ~r_req_tgl;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          r_cnt <= w_cnt_nxt;
          if (w_to_hit) begin
            r_timeout <= 1'b1;
          end
          if (w_ack_edge) begin
            r_done  <= {{(N_REQ-1){1'b0}}, 1'b1} << r_sel;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_rr_ptr <= (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_tgl = r_req_tgl;
  assign bus.o_data    = r_data;
  assign bus.o_sel     = r_sel;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_timeout = r_timeout;

  a_done_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(r_done));
  a_busy_state:  assert property (@(posedge i_clk) disable iff (!i_rst_n) r_busy == (r_state != S_IDLE));

endmodule

// File: tb/tb_cdc_chan_arbiter.sv
// Directed bench for cdc_chan_arbiter: reset, single transfer, round robin, timeout, spurious ack, mid-transfer reset.
module tb_cdc_chan_arbiter;
  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int TO    = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic tgl_exp;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] slice_val [4];

  always #5 clk = ~clk;

  cdc_chan_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  cdc_chan_arbiter #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT_CYC(TO)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called in IDLE with i_req already driven: the grant lands on the very next edge.
  task automatic grant(input string tag, input int sel, input logic [7:0] dat);
    step(1);
    tgl_exp = ~tgl_exp;
    chk({tag, ".tgl"},  32'(bus.o_req_tgl), 32'(tgl_exp));
    chk({tag, ".sel"},  32'(bus.o_sel),     sel);
    chk({tag, ".data"}, 32'(bus.o_data),    32'(dat));
    chk({tag, ".busy"}, 32'(bus.o_busy),    1);
    chk({tag, ".done0"}, 32'(bus.o_done),   0);
  endtask

  // Returns the ack after dly cycles; o_done must appear exactly 3 edges after the toggle.
  task automatic complete(input string tag, input int dly, input logic [3:0] done_exp);
    step(dly);
    bus.i_ack_tgl = ~bus.i_ack_tgl;
    step(2);
    chk({tag, ".early"}, 32'(bus.o_done), 0);
    step(1);
    chk({tag, ".done"},  32'(bus.o_done),    32'(done_exp));
    chk({tag, ".hold"},  32'(bus.o_req_tgl), 32'(tgl_exp));
    bus.i_req = bus.i_req & ~done_exp;
    step(1);
    chk({tag, ".clr"},   32'(bus.o_done), 0);
    chk({tag, ".idle"},  32'(bus.o_busy), 0);
  endtask

  initial begin
    slice_val[0] = 8'h11;
    slice_val[1] = 8'h22;
    slice_val[2] = 8'hA5;
    slice_val[3] = 8'h44;
    rst_n         = 1'b0;
    tgl_exp       = 1'b0;
    bus.i_req     = 4'b1111;
    bus.i_data    = 32'h44A5_2211;
    bus.i_ack_tgl = 1'b0;

    // T1: reset with all requests held
    step(3);
    chk("t1.tgl",  32'(bus.o_req_tgl), 0);
    chk("t1.data", 32'(bus.o_data),    0);
    chk("t1.sel",  32'(bus.o_sel),     0);
    chk("t1.busy", 32'(bus.o_busy),    0);
    chk("t1.done", 32'(bus.o_done),    0);
    chk("t1.to",   32'(bus.o_timeout), 0);
    rst_n = 1'b1;
    grant("t1g", 0, 8'h11);
    complete("t1c", 2, 4'b0001);
    bus.i_req = 4'b0000;

    // T2: single request, ack returned 5 cycles after the grant
    bus.i_req = 4'b0100;
    grant("t2g", 2, 8'hA5);
    complete("t2c", 5, 4'b0100);

    // Bring the pointer back to 0 before the round-robin check
    bus.i_req = 4'b1000;
    grant("t3a_g", 3, 8'h44);
    complete("t3a_c", 1, 4'b1000);

    // T3: two rounds of all-requesting, expect 0,1,2,3 twice
    for (int r = 0; r < 2; r++) begin
      bus.i_req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        grant($sformatf("t3r%0dk%0d_g", r, k), k, slice_val[k]);
        complete($sformatf("t3r%0dk%0d_c", r, k), 1 + k, 4'(1 << k));
      end
    end

    // T4: withhold the ack past the timeout
    bus.i_req = 4'b0010;
    grant("t4g", 1, 8'h22);
    step(63);
    chk("t4.to63",   32'(bus.o_timeout), 0);
    step(1);
    chk("t4.to64",   32'(bus.o_timeout), 1);
    chk("t4.tgl64",  32'(bus.o_req_tgl), 32'(tgl_exp));
    chk("t4.busy64", 32'(bus.o_busy),    1);
    step(20);
    chk("t4.to_hold",  32'(bus.o_timeout), 1);
    chk("t4.tgl_hold", 32'(bus.o_req_tgl), 32'(tgl_exp));
    chk("t4.no_done",  32'(bus.o_done),    0);
    complete("t4c", 1, 4'b0010);
    chk("t4.sticky", 32'(bus.o_timeout), 1);

    // T5: stray ack toggle while idle
    bus.i_req     = 4'b0000;
    bus.i_ack_tgl = ~bus.i_ack_tgl;
    for (int c = 0; c < 6; c++) begin
      step(1);
      chk($sformatf("t5.done%0d", c), 32'(bus.o_done), 0);
      chk($sformatf("t5.busy%0d", c), 32'(bus.o_busy), 0);
    end
    bus.i_req = 4'b0100;
    grant("t5g", 2, 8'hA5);
    complete("t5c", 3, 4'b0100);

    // T6: reset in the middle of WAIT_ACK
    bus.i_req = 4'b1000;
    grant("t6g", 3, 8'h44);
    step(2);
    rst_n         = 1'b0;
    bus.i_req     = 4'b0000;
    bus.i_ack_tgl = 1'b0;
    step(1);
    chk("t6.tgl",  32'(bus.o_req_tgl), 0);
    chk("t6.busy", 32'(bus.o_busy),    0);
    chk("t6.done", 32'(bus.o_done),    0);
    chk("t6.data", 32'(bus.o_data),    0);
    chk("t6.sel",  32'(bus.o_sel),     0);
    step(2);
    chk("t6.done_rst", 32'(bus.o_done), 0);
    rst_n     = 1'b1;
    tgl_exp   = 1'b0;
    bus.i_req = 4'b0100;
    grant("t6f_g", 2, 8'hA5);
    complete("t6f_c", 2, 4'b0100);
    chk("t6.to_clr", 32'(bus.o_timeout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
